// File: rtl/mem_load_unit.sv
// Sequential load unit: issues one or two aligned RAM reads per request, merges
// word-crossing accesses, extracts and extends the field, returns it on valid/ready.
module mem_load_unit #(
  parameter int WORD_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int RAM_LATENCY      = 1,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [WORD_WIDTH-1:0] ram_rd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WORD_WIDTH-1:0] rsp_data,
  output logic                  rsp_err
);

  localparam int NB = WORD_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD0   = 3'd1;
  localparam logic [2:0] WAIT0 = 3'd2;
  localparam logic [2:0] RD1   = 3'd3;
  localparam logic [2:0] WAIT1 = 3'd4;
  localparam logic [2:0] RESP  = 3'd5;

  logic [2:0]            state;
  logic [OW-1:0]         off_q;
  logic [1:0]            size_q;
  logic                  sgn_q, span_q, err_q;
  logic [CW-1:0]         lat_cnt;
  logic [WORD_WIDTH-1:0] lo_buf, hi_buf;

  // Request decode: byte span end beyond the word means a second read.
  logic [OW-1:0] req_off;
  logic [OW+1:0] req_end;
  logic          req_span, req_illegal, req_bad;

  always_comb begin
    req_off     = req_addr[OW-1:0];
    req_end     = (OW+2)'(req_off) + ((OW+2)'(1) << req_size);
    req_span    = req_end > (OW+2)'(NB);
    req_illegal = (NB < 8) && (req_size == 2'd3);
    req_bad     = req_illegal || (req_span && (ALLOW_MISALIGNED == 0));
  end

  logic lat_done;
  assign lat_done = (lat_cnt == CW'(RAM_LATENCY - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      off_q       <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      span_q      <= 1'b0;
      err_q       <= 1'b0;
      lat_cnt     <= '0;
      lo_buf      <= '0;
      hi_buf      <= '0;
      ram_rd_addr <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          off_q  <= req_off;
          size_q <= req_size;
          sgn_q  <= req_signed;
          span_q <= req_span;
          lo_buf <= '0;
          hi_buf <= '0;
          err_q  <= req_bad;
          if (req_bad) state <= RESP;
          else begin
            ram_rd_addr <= {req_addr[ADDR_WIDTH-1:OW], OW'(0)};
            state       <= RD0;
          end
        end
        RD0: begin
          lat_cnt <= '0;
          state   <= WAIT0;
        end
        WAIT0: if (lat_done) begin
          lo_buf <= ram_rd_data;
          if (span_q) begin
            // aligned address + NB wraps naturally at ADDR_WIDTH
            ram_rd_addr <= ram_rd_addr + ADDR_WIDTH'(NB);
            state       <= RD1;
          end else state <= RESP;
        end else lat_cnt <= lat_cnt + 1'b1;
        RD1: begin
          lat_cnt <= '0;
          state   <= WAIT1;
        end
        WAIT1: if (lat_done) begin
          hi_buf <= ram_rd_data;
          state  <= RESP;
        end else lat_cnt <= lat_cnt + 1'b1;
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Field extraction: shift merged pair down, keep nbytes lanes, fill the rest.
  logic [WORD_WIDTH-1:0] merged, ext;
  logic [3:0]            nbytes;
  logic                  sbit;

  always_comb begin
    merged = WORD_WIDTH'({hi_buf, lo_buf} >> {off_q, 3'b000});
    nbytes = 4'd1 << size_q;
    case (size_q)
      2'd0:    sbit = merged[7];
      2'd1:    sbit = merged[15];
      2'd2:    sbit = merged[31];
      default: sbit = merged[WORD_WIDTH-1];
    endcase
    ext = '0;
    for (int b = 0; b < NB; b++)
      ext[8*b +: 8] = (b < int'(nbytes)) ? merged[8*b +: 8] : {8{sbit & sgn_q}};
  end

  assign req_ready = (state == IDLE);
  assign ram_rd_en = (state == RD0) || (state == RD1);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) && err_q;
  assign rsp_data  = ((state == RESP) && !err_q) ? ext : '0;

endmodule
